// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle RV32I control unit. Combines the opcode decoder
//               with a FETCH/DECODE/EXEC/MEM/WB sequencer. It talks req/ack to
//               the instruction and data memories and start/done to an
//               optional multiply/divide unit. A bus timeout and an
//               undecodable opcode both lead to a sticky TRAP state. A
//               retired-instruction counter is also kept.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : ENABLE_M    - 1: R-type with instr_m_bit=1 goes to the MDU
//                             0: such an instruction is illegal
//               MEM_TIMEOUT - max wait cycles for an ack in FETCH/MEM
//                             (0 disables the timeout)
//               CNT_W       - width of the retired-instruction counter
// Ports       : clk, rst_n (synchronous, active-low)
//               opcode, instr_m_bit            - instruction fields from the IR
//               im_ack, dm_ack, mdu_done       - handshake returns
//               im_req, dm_req, dm_we          - memory requests
//               mdu_start, ir_write, pc_write,
//               reg_write                      - one-cycle control pulses
//               imm_type .. branch             - decoded datapath controls,
//                                                registered in DECODE
//               illegal_instr, bus_err, halted - trap status
//               state_o, retired               - observability
// ============================================================================
module multicycle_ctrl #(
    parameter int ENABLE_M    = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             instr_m_bit,
    input  logic             im_ack,
    input  logic             dm_ack,
    input  logic             mdu_done,
    output logic             im_req,
    output logic             dm_req,
    output logic             dm_we,
    output logic             mdu_start,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [2:0]       imm_type,
    output logic [2:0]       alu_op,
    output logic             pc_to_reg_src,
    output logic             alu_src,
    output logic             rd_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic [1:0]       branch,
    output logic             illegal_instr,
    output logic             bus_err,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM      = 3'd3,
        S_WB       = 3'd4,
        S_MDU_WAIT = 3'd5,
        S_TRAP     = 3'd7
    } state_t;

    typedef struct packed {
        logic [2:0] imm_type;
        logic [2:0] alu_op;
        logic       pc_to_reg_src;
        logic       alu_src;
        logic       rd_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       is_mdu;
        logic [1:0] branch;
    } dec_t;

    localparam logic [6:0] C_OP_R      = 7'b0110011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;

    state_t            r_state;
    state_t            w_next;
    dec_t              r_dec;
    dec_t              w_dec;
    logic              w_illegal;
    logic              r_illegal;
    logic              r_bus_err;
    logic [CNT_W-1:0]  r_retired;
    logic              w_timeout;

    logic w_im_req;
    logic w_dm_req;
    logic w_ir_write;
    logic w_pc_write;
    logic w_reg_write;
    logic w_mdu_start;
    logic w_set_illegal;
    logic w_set_bus_err;

    // ------------------------------------------------------------------
    // Opcode decoder. Illegal opcodes keep the default row.
    // ------------------------------------------------------------------
    always_comb begin
        w_dec        = '0;
        w_dec.alu_op = 3'd2;
        w_illegal    = 1'b0;
        case (opcode)
            C_OP_R: begin
                if (instr_m_bit) begin
                    if (ENABLE_M != 0) begin
                        w_dec.alu_op  = 3'd6;
                        w_dec.alu_src = 1'b1;
                        w_dec.reg_wr  = 1'b1;
                        w_dec.is_mdu  = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else begin
                    w_dec.alu_op  = 3'd0;
                    w_dec.alu_src = 1'b1;
                    w_dec.reg_wr  = 1'b1;
                end
            end
            C_OP_LOAD: begin
                w_dec.mem_read   = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_wr     = 1'b1;
            end
            C_OP_OPIMM: begin
                w_dec.alu_op = 3'd1;
                w_dec.reg_wr = 1'b1;
            end
            C_OP_JALR: begin
                w_dec.alu_op = 3'd3;
                w_dec.rd_src = 1'b1;
                w_dec.reg_wr = 1'b1;
                w_dec.branch = 2'd2;
            end
            C_OP_STORE: begin
                w_dec.imm_type  = 3'd1;
                w_dec.mem_write = 1'b1;
            end
            C_OP_BRANCH: begin
                w_dec.imm_type = 3'd2;
                w_dec.alu_op   = 3'd4;
                w_dec.alu_src  = 1'b1;
                w_dec.branch   = 2'd1;
            end
            C_OP_AUIPC: begin
                w_dec.imm_type      = 3'd3;
                w_dec.pc_to_reg_src = 1'b1;
                w_dec.rd_src        = 1'b1;
                w_dec.reg_wr        = 1'b1;
            end
            C_OP_LUI: begin
                w_dec.imm_type = 3'd3;
                w_dec.alu_op   = 3'd5;
                w_dec.reg_wr   = 1'b1;
            end
            C_OP_JAL: begin
                w_dec.imm_type = 3'd4;
                w_dec.rd_src   = 1'b1;
                w_dec.reg_wr   = 1'b1;
                w_dec.branch   = 2'd3;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-wait timeout. The counter is zero whenever the FSM is not
    // actively waiting, so it is clear on every entry to FETCH or MEM.
    // An ack in the final cycle takes priority over the timeout.
    // ------------------------------------------------------------------
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

            logic [WAIT_W-1:0] r_wait_cnt;
            logic              w_waiting;

            assign w_waiting = ((r_state == S_FETCH) && !im_ack) ||
                               ((r_state == S_MEM)   && !dm_ack);
            assign w_timeout = w_waiting &&
                               (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wait_cnt <= '0;
                end else if (w_waiting && !w_timeout) begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end else begin
                    r_wait_cnt <= '0;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and control pulses
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        w_im_req      = 1'b0;
        w_dm_req      = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_mdu_start   = 1'b0;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_im_req = 1'b1;
                if (im_ack) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_set_illegal = 1'b1;
                    w_next        = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_dec.is_mdu) begin
                    w_mdu_start = 1'b1;
                    w_next      = S_MDU_WAIT;
                end else if (r_dec.mem_read || r_dec.mem_write) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MDU_WAIT: begin
                if (mdu_done) begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_dm_req = 1'b1;
                if (dm_ack) begin
                    // Stores have nothing to write back, so they retire here.
                    if (r_dec.mem_write) begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_set_bus_err = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_WB: begin
                w_reg_write = r_dec.reg_wr;
                w_pc_write  = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
            if (w_pc_write) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Decoded fields are captured in DECODE and held until the next DECODE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dec        <= '0;
            r_dec.alu_op <= 3'd2;
        end else if (r_state == S_DECODE) begin
            r_dec <= w_dec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Requests and pulses are gated by rst_n so that nothing is
    // issued while reset is held, even though the state already reads FETCH.
    // ------------------------------------------------------------------
    assign im_req    = w_im_req    & rst_n;
    assign dm_req    = w_dm_req    & rst_n;
    assign dm_we     = w_dm_req    & rst_n & r_dec.mem_write;
    assign ir_write  = w_ir_write  & rst_n;
    assign pc_write  = w_pc_write  & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign mdu_start = w_mdu_start & rst_n;

    assign imm_type      = r_dec.imm_type;
    assign alu_op        = r_dec.alu_op;
    assign pc_to_reg_src = r_dec.pc_to_reg_src;
    assign alu_src       = r_dec.alu_src;
    assign rd_src        = r_dec.rd_src;
    assign mem_read      = r_dec.mem_read;
    assign mem_write     = r_dec.mem_write;
    assign mem_to_reg    = r_dec.mem_to_reg;
    assign branch        = r_dec.branch;

    assign illegal_instr = r_illegal;
    assign bus_err       = r_bus_err;
    assign halted        = (r_state == S_TRAP);
    assign state_o       = r_state;
    assign retired       = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl. Two
//               instances share all inputs: "a" with ENABLE_M=1 and "b" with
//               ENABLE_M=0, both with MEM_TIMEOUT=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       instr_m_bit;
    logic       im_ack;
    logic       dm_ack;
    logic       mdu_done;

    logic        a_im_req, a_dm_req, a_dm_we, a_mdu_start, a_ir_write, a_pc_write, a_reg_write;
    logic [2:0]  a_imm_type, a_alu_op, a_state;
    logic        a_pc_to_reg_src, a_alu_src, a_rd_src, a_mem_read, a_mem_write, a_mem_to_reg;
    logic [1:0]  a_branch;
    logic        a_illegal, a_bus_err, a_halted;
    logic [31:0] a_retired;

    logic        b_im_req, b_dm_req, b_dm_we, b_mdu_start, b_ir_write, b_pc_write, b_reg_write;
    logic [2:0]  b_imm_type, b_alu_op, b_state;
    logic        b_pc_to_reg_src, b_alu_src, b_rd_src, b_mem_read, b_mem_write, b_mem_to_reg;
    logic [1:0]  b_branch;
    logic        b_illegal, b_bus_err, b_halted;
    logic [31:0] b_retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ENABLE_M(1), .MEM_TIMEOUT(8), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_m_bit(instr_m_bit),
        .im_ack(im_ack), .dm_ack(dm_ack), .mdu_done(mdu_done),
        .im_req(a_im_req), .dm_req(a_dm_req), .dm_we(a_dm_we), .mdu_start(a_mdu_start),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .imm_type(a_imm_type), .alu_op(a_alu_op), .pc_to_reg_src(a_pc_to_reg_src),
        .alu_src(a_alu_src), .rd_src(a_rd_src), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_to_reg(a_mem_to_reg), .branch(a_branch),
        .illegal_instr(a_illegal), .bus_err(a_bus_err), .halted(a_halted),
        .state_o(a_state), .retired(a_retired)
    );

    multicycle_ctrl #(.ENABLE_M(0), .MEM_TIMEOUT(8), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_m_bit(instr_m_bit),
        .im_ack(im_ack), .dm_ack(dm_ack), .mdu_done(mdu_done),
        .im_req(b_im_req), .dm_req(b_dm_req), .dm_we(b_dm_we), .mdu_start(b_mdu_start),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .imm_type(b_imm_type), .alu_op(b_alu_op), .pc_to_reg_src(b_pc_to_reg_src),
        .alu_src(b_alu_src), .rd_src(b_rd_src), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_to_reg(b_mem_to_reg), .branch(b_branch),
        .illegal_instr(b_illegal), .bus_err(b_bus_err), .halted(b_halted),
        .state_o(b_state), .retired(b_retired)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        im_ack   = 1'b0;
        dm_ack   = 1'b0;
        mdu_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        im_ack      = 1'b1;
        dm_ack      = 1'b1;
        mdu_done    = 1'b0;
        opcode      = 7'b1111111;
        instr_m_bit = 1'b0;
        step();
        step();
        #1;
        checks++;
        if ({a_state, a_im_req, a_ir_write, a_pc_write, a_reg_write, a_dm_req, a_mdu_start} !== 9'b000_000000) begin
            errors++;
            $display("FAIL reset_pulses got=%b exp=%b",
                     {a_state, a_im_req, a_ir_write, a_pc_write, a_reg_write, a_dm_req, a_mdu_start}, 9'b0);
        end
        checks++;
        if ({a_illegal, a_bus_err, a_halted} !== 3'b000 || a_retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_status got=%b/%0d exp=000/0", {a_illegal, a_bus_err, a_halted}, a_retired);
        end
        checks++;
        if ({a_imm_type, a_alu_op, a_pc_to_reg_src, a_alu_src, a_rd_src, a_mem_read,
             a_mem_write, a_mem_to_reg, a_branch} !== {3'd0, 3'd2, 8'b0}) begin
            errors++;
            $display("FAIL reset_decode got imm=%0d alu=%0d exp imm=0 alu=2 rest=0", a_imm_type, a_alu_op);
        end
        rst_n  = 1'b1;
        im_ack = 1'b0;
        dm_ack = 1'b0;
        #1;
        checks++;
        if ({a_state, a_im_req} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release got state=%0d im_req=%b exp state=0 im_req=1", a_state, a_im_req);
        end
        step();
    endtask

    task automatic test_opimm();
        logic [2:0] exp_st [0:3];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        opcode      = 7'b0010011;
        instr_m_bit = 1'b0;
        im_ack      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (a_state !== exp_st[i % 4]) begin
                errors++;
                $display("FAIL opimm_state cyc=%0d got=%0d exp=%0d", i, a_state, exp_st[i % 4]);
            end
            checks++;
            if ({a_ir_write, a_pc_write, a_reg_write} !== {(i % 4) == 0, (i % 4) == 3, (i % 4) == 3}) begin
                errors++;
                $display("FAIL opimm_pulses cyc=%0d got=%b exp=%b", i,
                         {a_ir_write, a_pc_write, a_reg_write}, {(i % 4) == 0, (i % 4) == 3, (i % 4) == 3});
            end
            if (i == 2) begin
                checks++;
                if ({a_imm_type, a_alu_op, a_alu_src, a_branch} !== {3'd0, 3'd1, 1'b0, 2'd0}) begin
                    errors++;
                    $display("FAIL opimm_decode got imm=%0d alu=%0d src=%b exp imm=0 alu=1 src=0",
                             a_imm_type, a_alu_op, a_alu_src);
                end
            end
            step();
        end
        #1;
        checks++;
        if (a_retired !== 32'd3 || a_state !== 3'd0) begin
            errors++;
            $display("FAIL opimm_retired got=%0d state=%0d exp=3 state=0", a_retired, a_state);
        end
    endtask

    task automatic test_load();
        logic [2:0] exp_st [0:7];
        int rw_cnt;
        int req_cnt;
        logic exp_req;
        exp_st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        rw_cnt  = 0;
        req_cnt = 0;
        opcode  = 7'b0000011;
        im_ack  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dm_ack = (i == 6);
            #1;
            exp_req = (i >= 3) && (i <= 6);
            checks++;
            if (a_state !== exp_st[i]) begin
                errors++;
                $display("FAIL load_state cyc=%0d got=%0d exp=%0d", i, a_state, exp_st[i]);
            end
            checks++;
            if ({a_dm_req, a_dm_we} !== {exp_req, 1'b0}) begin
                errors++;
                $display("FAIL load_dmreq cyc=%0d got=%b exp=%b", i, {a_dm_req, a_dm_we}, {exp_req, 1'b0});
            end
            if (i == 3) begin
                checks++;
                if ({a_mem_read, a_mem_to_reg, a_mem_write, a_alu_op} !== {3'b110, 3'd2}) begin
                    errors++;
                    $display("FAIL load_decode got rd=%b m2r=%b wr=%b alu=%0d exp 1 1 0 2",
                             a_mem_read, a_mem_to_reg, a_mem_write, a_alu_op);
                end
            end
            if (a_dm_req) req_cnt++;
            if (a_reg_write) rw_cnt++;
            step();
        end
        dm_ack = 1'b0;
        #1;
        checks++;
        if (req_cnt != 4 || rw_cnt != 1) begin
            errors++;
            $display("FAIL load_counts got req=%0d rw=%0d exp req=4 rw=1", req_cnt, rw_cnt);
        end
        checks++;
        if (a_state !== 3'd0 || a_retired !== 32'd4) begin
            errors++;
            $display("FAIL load_end got state=%0d retired=%0d exp 0 4", a_state, a_retired);
        end
    endtask

    task automatic test_store();
        logic [2:0] exp_st [0:4];
        logic exp_req;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        opcode = 7'b0100011;
        im_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dm_ack = (i == 4);
            #1;
            exp_req = (i >= 3);
            checks++;
            if (a_state !== exp_st[i]) begin
                errors++;
                $display("FAIL store_state cyc=%0d got=%0d exp=%0d", i, a_state, exp_st[i]);
            end
            checks++;
            if ({a_dm_req, a_dm_we, a_reg_write, a_pc_write} !== {exp_req, exp_req, 1'b0, i == 4}) begin
                errors++;
                $display("FAIL store_ctl cyc=%0d got=%b exp=%b", i,
                         {a_dm_req, a_dm_we, a_reg_write, a_pc_write}, {exp_req, exp_req, 1'b0, i == 4});
            end
            if (i == 2) begin
                checks++;
                if ({a_imm_type, a_mem_write, a_mem_read} !== {3'd1, 2'b10}) begin
                    errors++;
                    $display("FAIL store_decode got imm=%0d wr=%b rd=%b exp 1 1 0",
                             a_imm_type, a_mem_write, a_mem_read);
                end
            end
            step();
        end
        dm_ack = 1'b0;
        #1;
        checks++;
        if (a_state !== 3'd0 || a_retired !== 32'd5) begin
            errors++;
            $display("FAIL store_end got state=%0d retired=%0d exp 0 5", a_state, a_retired);
        end
    endtask

    task automatic test_rtype();
        logic [2:0] exp_st [0:3];
        exp_st      = '{3'd0, 3'd1, 3'd2, 3'd4};
        opcode      = 7'b0110011;
        instr_m_bit = 1'b0;
        im_ack      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (a_state !== exp_st[i] || b_state !== exp_st[i]) begin
                errors++;
                $display("FAIL rtype_state cyc=%0d got a=%0d b=%0d exp=%0d", i, a_state, b_state, exp_st[i]);
            end
            if (i == 2) begin
                checks++;
                if ({a_alu_op, a_alu_src, b_alu_op, b_illegal} !== {3'd0, 1'b1, 3'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL rtype_decode got a_alu=%0d a_src=%b b_alu=%0d b_ill=%b exp 0 1 0 0",
                             a_alu_op, a_alu_src, b_alu_op, b_illegal);
                end
            end
            step();
        end
        #1;
        checks++;
        if (a_retired !== 32'd6 || b_retired !== 32'd6) begin
            errors++;
            $display("FAIL rtype_retired got a=%0d b=%0d exp 6", a_retired, b_retired);
        end
    endtask

    task automatic test_mdu();
        logic [2:0] exp_st [0:6];
        int start_cnt;
        exp_st      = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'd4};
        start_cnt   = 0;
        opcode      = 7'b0110011;
        instr_m_bit = 1'b1;
        im_ack      = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mdu_done = (i == 5);
            #1;
            checks++;
            if (a_state !== exp_st[i]) begin
                errors++;
                $display("FAIL mdu_state cyc=%0d got=%0d exp=%0d", i, a_state, exp_st[i]);
            end
            checks++;
            if (a_mdu_start !== (i == 2)) begin
                errors++;
                $display("FAIL mdu_start cyc=%0d got=%b exp=%b", i, a_mdu_start, i == 2);
            end
            if (i == 3) begin
                checks++;
                if (a_alu_op !== 3'd6) begin
                    errors++;
                    $display("FAIL mdu_aluop got=%0d exp=6", a_alu_op);
                end
            end
            if (i >= 2) begin
                checks++;
                if ({b_state, b_illegal, b_halted, b_im_req, b_mdu_start} !== {3'd7, 4'b1100}) begin
                    errors++;
                    $display("FAIL nom_trap cyc=%0d got state=%0d ill=%b halt=%b req=%b start=%b exp 7 1 1 0 0",
                             i, b_state, b_illegal, b_halted, b_im_req, b_mdu_start);
                end
            end
            if (a_mdu_start) start_cnt++;
            step();
        end
        mdu_done    = 1'b0;
        instr_m_bit = 1'b0;
        #1;
        checks++;
        if (start_cnt != 1 || a_state !== 3'd0 || a_retired !== 32'd7 || b_retired !== 32'd6) begin
            errors++;
            $display("FAIL mdu_end got starts=%0d state=%0d a_ret=%0d b_ret=%0d exp 1 0 7 6",
                     start_cnt, a_state, a_retired, b_retired);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        #1;
        checks++;
        if ({b_illegal, b_halted, b_state} !== {2'b00, 3'd0}) begin
            errors++;
            $display("FAIL illegal_cleared got ill=%b halt=%b state=%0d exp 0 0 0", b_illegal, b_halted, b_state);
        end
        opcode = 7'b1111111;
        im_ack = 1'b1;
        step();
        #1;
        checks++;
        if (a_state !== 3'd1 || a_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_decode got state=%0d ill=%b exp 1 0", a_state, a_illegal);
        end
        step();
        #1;
        checks++;
        if ({a_state, a_illegal, a_halted, a_bus_err, a_alu_op, a_imm_type} !== {3'd7, 3'b110, 3'd2, 3'd0}) begin
            errors++;
            $display("FAIL illegal_trap got state=%0d ill=%b halt=%b berr=%b alu=%0d exp 7 1 1 0 2",
                     a_state, a_illegal, a_halted, a_bus_err, a_alu_op);
        end
        step();
        step();
        step();
        #1;
        checks++;
        if ({a_state, a_im_req, a_ir_write, a_halted} !== {3'd7, 3'b001} || a_retired !== 32'd0) begin
            errors++;
            $display("FAIL illegal_stay got state=%0d req=%b halt=%b ret=%0d exp 7 0 1 0",
                     a_state, a_im_req, a_halted, a_retired);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = 7'b0010011;
        #1;
        checks++;
        if (a_illegal !== 1'b0 || a_halted !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared got ill=%b halt=%b exp 0 0", a_illegal, a_halted);
        end
        im_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if ({a_state, a_im_req} !== {3'd0, 1'b1}) begin
                errors++;
                $display("FAIL timeout_wait cyc=%0d got state=%0d req=%b exp 0 1", i, a_state, a_im_req);
            end
            step();
        end
        #1;
        checks++;
        if ({a_state, a_bus_err, a_halted, a_illegal, a_im_req} !== {3'd7, 4'b1100}) begin
            errors++;
            $display("FAIL timeout_trap got state=%0d berr=%b halt=%b ill=%b req=%b exp 7 1 1 0 0",
                     a_state, a_bus_err, a_halted, a_illegal, a_im_req);
        end
        do_reset();
        #1;
        checks++;
        if (a_bus_err !== 1'b0) begin
            errors++;
            $display("FAIL berr_cleared got=%b exp=0", a_bus_err);
        end
        for (int i = 0; i < 8; i++) begin
            im_ack = (i == 7);
            #1;
            checks++;
            if (a_state !== 3'd0) begin
                errors++;
                $display("FAIL late_ack_wait cyc=%0d got=%0d exp=0", i, a_state);
            end
            step();
        end
        im_ack = 1'b0;
        #1;
        checks++;
        if ({a_state, a_bus_err, a_halted} !== {3'd1, 2'b00}) begin
            errors++;
            $display("FAIL late_ack got state=%0d berr=%b halt=%b exp 1 0 0", a_state, a_bus_err, a_halted);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        opcode = 7'b0010011;
        im_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        opcode = 7'b0000011;
        for (int i = 0; i < 3; i++) step();
        #1;
        checks++;
        if ({a_state, a_dm_req} !== {3'd3, 1'b1} || a_retired !== 32'd1) begin
            errors++;
            $display("FAIL midmem_pre got state=%0d req=%b ret=%0d exp 3 1 1", a_state, a_dm_req, a_retired);
        end
        rst_n = 1'b0;
        step();
        #1;
        checks++;
        if ({a_state, a_dm_req, a_illegal, a_bus_err, a_halted} !== {3'd0, 4'b0000} || a_retired !== 32'd0) begin
            errors++;
            $display("FAIL midmem_reset got state=%0d req=%b ret=%0d exp 0 0 0", a_state, a_dm_req, a_retired);
        end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_opimm();
        test_load();
        test_store();
        test_rtype();
        test_mdu();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
